rw_responder: RTL
=================

Name: rw_responder

Overview:
- Memory-side responder for the two-lane, four-phase A/RW/W1/W2/Ack handshake that the write and read test initiators drive.
- Synchronises the initiator's control lines and decodes RW.
- Writes to or reads from a local nibble-pair store after a programmable latency, then raises Ack and the per-lane data acknowledges.
- Sits opposite the initiator in 16nm_Tests and is the responder cell that initiator benches connect to.

Parameters:
- ADDR_W, 8, number of low address bits decoded; store depth is 2**ADDR_W entries of 8 bits ({lane2, lane1}).
- LAT, 2, cycles from request capture to Ack; legal range 1..15.
- SYNC_STAGES, 2, flop stages on RW and RDataAck; 0 means sampled directly.

Ports:
- CLK  input  1  sole clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- A  input  17  request address; stable while RW != 00.
- RW  input  2  00 idle, 01 write, 10 read, 11 reserved.
- W1  input  4  write data, lane 1.
- W2  input  4  write data, lane 2.
- WdataAck  output  2  per-lane write-data accepted (bit0 lane 1, bit1 lane 2).
- R1  output  4  read data, lane 1.
- R2  output  4  read data, lane 2.
- RDataAck  input  2  per-lane read-data consumed, driven by the initiator.
- Ack  output  1  request acknowledge.
- ERR  output  1  the current acknowledged request was rejected.
- VDD  input  1  supply pin, kept for schematic pin match, functionally unused.
- VSS  input  1  supply pin, kept for schematic pin match, functionally unused.

Behaviour:
- Reset (async, RST_N=0):
  - Ack=0, WdataAck=00, R1=R2=0, ERR=0.
  - State goes to IDLE, latency counter cleared, synchroniser flops cleared.
  - Store contents are not reset.
  - Release is taken on the next CLK edge.
- Synchronisers: RW_s and RDA_s are RW and RDataAck delayed by SYNC_STAGES flops. A, W1 and W2 are not synchronised; the protocol guarantees they are stable once RW_s != 00.
- IDLE: on an edge with RW_s != 00:
  - capture op=RW_s, addr=A, wd={W2,W1};
  - load cnt=LAT-1; go to BUSY.
- BUSY:
  - While cnt != 0, decrement.
  - On the edge where cnt == 0, execute and go to HOLD, with Ack=1 from that edge.
  - op=01, in range: store[addr[ADDR_W-1:0]] <= wd; WdataAck=11.
  - op=10, in range: R1 <= store[addr][3:0], R2 <= store[addr][7:4].
  - Out of range (addr[16:ADDR_W] != 0) or op=11: no store access; ERR=1; WdataAck=00; R1=R2=0.
  - RW changes during BUSY are ignored; the captured request always completes.
- Latency: with RW applied before edge 1, Ack rises on edge SYNC_STAGES+LAT+1 (edge 5 at defaults).
- HOLD, write or error op: on the first edge with RW_s==00, clear Ack, WdataAck and ERR; go to IDLE.
- HOLD, successful read: wait until RW_s==00 and RDA_s==11, in either order or together. On that edge, clear Ack and R1/R2; go to DRAIN.
- DRAIN: on the first edge with RDA_s==00, go to IDLE. A new RW seen in DRAIN is not captured until IDLE.
- Partial RDataAck (01 or 10) never completes a read; Ack holds indefinitely.
- A request withdrawn during BUSY still completes; Ack pulses for exactly one cycle, then falls because RW_s==00 in HOLD.
- A new request can be captured no earlier than the edge after the return to IDLE. Back-to-back requests need RW to pass through 00.
- Mid-operation reset aborts the transaction with no partial store write. A write completed before reset persists.

Test Plan:
- Reset, then write A=17'h00042 RW=01 W1=4'h1 W2=4'h1 -> Ack and WdataAck=11 on edge 5, ERR=0. Drop RW=00 -> Ack=0 and WdataAck=00 three edges later.
- Read A=17'h00042 RW=10 -> Ack on edge 5 with R1=4'h1 R2=4'h1. Drop RW, raise RDataAck=11 -> Ack=0, R=0. Drop RDataAck -> IDLE.
- Write A=17'h11111 RW=01 W=1/1 -> Ack with ERR=1 and WdataAck=00. Read of 17'h00011 returns its unchanged contents.
- RW=11 -> Ack, ERR=1, no store change. Read with RDataAck=01 only -> Ack held for 20 cycles until RDataAck becomes 11.
- Sweep LAT=1 and LAT=15 with SYNC_STAGES=0 -> Ack on edges 2 and 16 respectively. Withdraw RW at edge 2 of BUSY -> Ack lasts exactly 1 cycle.
- Assert RST_N=0 during BUSY of a write to 17'h00005 -> outputs clear immediately. A later read of 17'h00005 returns the pre-write value.

Source files
------------

// File: rtl/rw_responder.sv
// rw_responder: memory-side responder for the two-lane four-phase A/RW/W1/W2/Ack handshake.
// RW and RDataAck are synchronised, requests complete after LAT cycles against a 2**ADDR_W x 8 store.
module rw_responder #(
  parameter int ADDR_W      = 8,
  parameter int LAT         = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [16:0] A,
  input  logic [1:0]  RW,
  input  logic [3:0]  W1,
  input  logic [3:0]  W2,
  output logic [1:0]  WdataAck,
  output logic [3:0]  R1,
  output logic [3:0]  R2,
  input  logic [1:0]  RDataAck,
  output logic        Ack,
  output logic        ERR,
  input  logic        VDD,
  input  logic        VSS
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  // Address bits above the decoded window must all be zero for a legal access.
  function automatic logic addr_in_range(input logic [16:0] addr);
    return (addr >> ADDR_W) == 17'd0;
  endfunction

  state_t       state_r;
  state_t       state_nxt_s;
  logic [3:0]   cnt_r;
  logic [3:0]   cnt_nxt_s;
  logic [1:0]   op_r;
  logic [1:0]   op_nxt_s;
  logic [16:0]  addr_r;
  logic [16:0]  addr_nxt_s;
  logic [7:0]   wd_r;
  logic [7:0]   wd_nxt_s;

  logic         ack_r;
  logic         ack_nxt_s;
  logic [1:0]   wdack_r;
  logic [1:0]   wdack_nxt_s;
  logic [3:0]   r1_r;
  logic [3:0]   r1_nxt_s;
  logic [3:0]   r2_r;
  logic [3:0]   r2_nxt_s;
  logic         err_r;
  logic         err_nxt_s;

  logic [1:0]   rw_s;
  logic [1:0]   rda_s;
  logic         in_range_s;
  logic         bad_req_s;
  logic         read_ok_s;
  logic         read_done_s;
  logic         store_we_s;
  logic [7:0]   store_rd_s;
  logic [7:0]   store_r [DEPTH];

  // Supply pins exist only for schematic pin matching.
  logic         unused_supply_s;
  assign unused_supply_s = VDD ^ VSS;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign rw_s  = RW;
      assign rda_s = RDataAck;
    end else begin : g_sync
      logic [1:0] rw_q_r  [SYNC_STAGES];
      logic [1:0] rda_q_r [SYNC_STAGES];

      // Synchroniser chains for the initiator's control lines.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            rw_q_r[i]  <= 2'b00;
            rda_q_r[i] <= 2'b00;
          end
        end else begin
          rw_q_r[0]  <= RW;
          rda_q_r[0] <= RDataAck;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            rw_q_r[i]  <= rw_q_r[i-1];
            rda_q_r[i] <= rda_q_r[i-1];
          end
        end
      end

      assign rw_s  = rw_q_r[SYNC_STAGES-1];
      assign rda_s = rda_q_r[SYNC_STAGES-1];
    end
  endgenerate

  assign in_range_s  = addr_in_range(addr_r);
  assign bad_req_s   = (!in_range_s) || (op_r == 2'b11);
  assign read_ok_s   = (op_r == 2'b10) && in_range_s;
  assign read_done_s = (rw_s == 2'b00) && (rda_s == 2'b11);
  assign store_rd_s  = store_r[addr_r[ADDR_W-1:0]];

  // State, counter, captured request and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      op_r    <= 2'b00;
      addr_r  <= 17'd0;
      wd_r    <= 8'd0;
      ack_r   <= 1'b0;
      wdack_r <= 2'b00;
      r1_r    <= 4'd0;
      r2_r    <= 4'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      op_r    <= op_nxt_s;
      addr_r  <= addr_nxt_s;
      wd_r    <= wd_nxt_s;
      ack_r   <= ack_nxt_s;
      wdack_r <= wdack_nxt_s;
      r1_r    <= r1_nxt_s;
      r2_r    <= r2_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  // Next-state, latency counter and request capture.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    op_nxt_s    = op_r;
    addr_nxt_s  = addr_r;
    wd_nxt_s    = wd_r;
    case (state_r)
      IDLE: begin
        if (rw_s != 2'b00) begin
          op_nxt_s    = rw_s;
          addr_nxt_s  = A;
          wd_nxt_s    = {W2, W1};
          cnt_nxt_s   = CNT_LOAD;
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r != 4'd0) begin
          cnt_nxt_s = cnt_r - 4'd1;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      HOLD: begin
        if (read_ok_s) begin
          if (read_done_s) begin
            state_nxt_s = DRAIN;
          end else begin
            state_nxt_s = HOLD;
          end
        end else begin
          if (rw_s == 2'b00) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = HOLD;
          end
        end
      end
      DRAIN: begin
        if (rda_s == 2'b00) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output updates and store write enable, applied on the execute and release edges.
  always_comb begin
    ack_nxt_s   = ack_r;
    wdack_nxt_s = wdack_r;
    r1_nxt_s    = r1_r;
    r2_nxt_s    = r2_r;
    err_nxt_s   = err_r;
    store_we_s  = 1'b0;
    case (state_r)
      BUSY: begin
        if (cnt_r == 4'd0) begin
          ack_nxt_s = 1'b1;
          if (bad_req_s) begin
            err_nxt_s   = 1'b1;
            wdack_nxt_s = 2'b00;
            r1_nxt_s    = 4'd0;
            r2_nxt_s    = 4'd0;
          end else if (op_r == 2'b01) begin
            err_nxt_s   = 1'b0;
            store_we_s  = 1'b1;
            wdack_nxt_s = 2'b11;
          end else begin
            err_nxt_s   = 1'b0;
            r1_nxt_s    = store_rd_s[3:0];
            r2_nxt_s    = store_rd_s[7:4];
          end
        end else begin
          ack_nxt_s = 1'b0;
        end
      end
      HOLD: begin
        if (read_ok_s) begin
          if (read_done_s) begin
            ack_nxt_s = 1'b0;
            r1_nxt_s  = 4'd0;
            r2_nxt_s  = 4'd0;
          end else begin
            ack_nxt_s = 1'b1;
          end
        end else begin
          if (rw_s == 2'b00) begin
            ack_nxt_s   = 1'b0;
            wdack_nxt_s = 2'b00;
            err_nxt_s   = 1'b0;
          end else begin
            ack_nxt_s = 1'b1;
          end
        end
      end
      default: begin
        ack_nxt_s = ack_r;
      end
    endcase
  end

  // Store array; contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (store_we_s) begin
      store_r[addr_r[ADDR_W-1:0]] <= wd_r;
    end
  end

  assign Ack      = ack_r;
  assign WdataAck = wdack_r;
  assign R1       = r1_r;
  assign R2       = r2_r;
  assign ERR      = err_r;

endmodule
